// File: rtl/op_datapath_pkg.sv
// op_datapath shared types: multiply FSM states and default operand width.
package op_datapath_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/op_datapath_if.sv
// Controller <-> op_datapath handshake bundle: enables in, completion flags
// and product out.
interface op_datapath_if
  import op_datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic               habA;
  logic               habB;
  logic               habOp;
  logic               din;
  logic               fimA;
  logic               fimB;
  logic               fimOp;
  logic [2*WIDTH-1:0] result;

  modport master (
    output habA, habB, habOp, din,
    input  fimA, fimB, fimOp, result
  );

  modport slave (
    input  habA, habB, habOp, din,
    output fimA, fimB, fimOp, result
  );
endinterface

// File: rtl/serial_loader.sv
// MSB-first serial operand loader with bit counter and level-held done flag.
module serial_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             hold_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] data_o,
  output logic             done_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  // hold_i freezes everything, including the counter, while the
  // other loader owns the shared serial input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!hold_i) begin
      if (!en_i) begin
        cnt_q  <= '0;
        done_q <= 1'b0;
      end else if (!done_q) begin
        data_q <= {data_q[WIDTH-2:0], din_i};
        cnt_q  <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          done_q <= 1'b1;
      end
    end
  end

  assign data_o = data_q;
  assign done_o = done_q;
endmodule

// File: rtl/op_datapath.sv
// Serial operand load plus shift-and-add multiply datapath.
// Define OP_DATAPATH_SIGNED_EN for a two's-complement multiply.
module op_datapath
  import op_datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst,
  op_datapath_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic             fim_a;
  logic             fim_b;
  logic             hold_b;

  assign hold_b = bus.habA & bus.habB;

  serial_loader #(.WIDTH(WIDTH)) u_ld_a (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.habA),
    .hold_i (1'b0),
    .din_i  (bus.din),
    .data_o (reg_a),
    .done_o (fim_a)
  );

  serial_loader #(.WIDTH(WIDTH)) u_ld_b (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.habB),
    .hold_i (hold_b),
    .din_i  (bus.din),
    .data_o (reg_b),
    .done_o (fim_b)
  );

  mul_state_e       state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [PW-1:0]    res_q, res_d;
  logic             fim_op_q, fim_op_d;
`ifdef OP_DATAPATH_SIGNED_EN
  logic             sign_q, sign_d;

  function automatic logic [WIDTH-1:0] abs_w(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    res_d    = res_q;
    fim_op_d = fim_op_q;
`ifdef OP_DATAPATH_SIGNED_EN
    sign_d   = sign_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.habOp && !fim_op_q)
          state_d = S_INIT;
      end
      S_INIT: begin
        if (!bus.habOp) begin
          state_d = S_IDLE;
        end else begin
`ifdef OP_DATAPATH_SIGNED_EN
          mcand_d  = {{WIDTH{1'b0}}, abs_w(reg_a)};
          mplier_d = abs_w(reg_b);
          sign_d   = reg_a[WIDTH-1] ^ reg_b[WIDTH-1];
`else
          mcand_d  = {{WIDTH{1'b0}}, reg_a};
          mplier_d = reg_b;
`endif
          acc_d    = '0;
          iter_d   = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.habOp) begin
          state_d = S_IDLE;
        end else begin
          if (mplier_q[0])
            acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          iter_d   = iter_q + CW'(1);
          if (iter_q == CW'(WIDTH - 1))
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.habOp) begin
          state_d  = S_IDLE;
          fim_op_d = 1'b0;
        end else begin
          fim_op_d = 1'b1;
`ifdef OP_DATAPATH_SIGNED_EN
          res_d    = sign_q ? (~acc_q + PW'(1)) : acc_q;
`else
          res_d    = acc_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      res_q    <= '0;
      fim_op_q <= 1'b0;
`ifdef OP_DATAPATH_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      res_q    <= res_d;
      fim_op_q <= fim_op_d;
`ifdef OP_DATAPATH_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign bus.fimA   = fim_a;
  assign bus.fimB   = fim_b;
  assign bus.fimOp  = fim_op_q;
  assign bus.result = res_q;
endmodule

// File: doc/op_datapath.md
# op_datapath

Datapath stage directly downstream of the load/operate control FSM. It consumes the enables `habA`, `habB` and `habOp` and returns the matching completion flags `fimA`, `fimB` and `fimOp`. It shifts two operands in serially over one data bit, then runs a shift-and-add multiply. The completion flags close the handshake loop with the controller; the product is presented to the rest of the design.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; product is 2*WIDTH.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `habA`  input  1  enable: load operand A.
- `habB`  input  1  enable: load operand B.
- `habOp`  input  1  enable: run the multiply.
- `din`  input  1  serial operand bit, MSB first.
- `fimA`  output  1  operand A loaded.
- `fimB`  output  1  operand B loaded.
- `fimOp`  output  1  multiply complete.
- `result`  output  2*WIDTH  product.

## Operation
- Reset clears all of the following: `regA`, `regB`, the load counters, the multiply state, `result`, `fimA`, `fimB`, `fimOp`.

**Load A**
- On each rising edge with `habA`=1 and `fimA`=0: `regA` <= {`regA`[WIDTH-2:0], `din`} and the A counter increments.
- After the WIDTH-th sampled bit, `fimA` is set.
- Once `fimA`=1, no further shifts occur while `habA` stays high.
- When `habA`=0, `fimA` and the counter clear on the next edge.
- If `habA` drops mid-load, the counter clears and the partial operand is invalid. The next load restarts from bit 0.

**Load B**
- Identical to load A, using `habB`, `regB` and `fimB`.
- `habA` and `habB` both high: A has priority; B holds its counter and does not shift.

**Multiply state machine**
- IDLE:
  - `habOp`=1 and `fimOp`=0 → INIT.
- INIT, one cycle:
  - Latch multiplicand = `regA` zero-extended to 2*WIDTH.
  - Latch multiplier = `regB`.
  - Accumulator = 0; iteration counter = 0.
  - Next state: RUN.
- RUN, WIDTH cycles. Each cycle:
  - If multiplier[0]=1, accumulator += multiplicand.
  - Multiplicand shifts left by 1; multiplier shifts right by 1.
  - After the WIDTH-th iteration → DONE.
- DONE:
  - `result` <= accumulator and `fimOp`=1.
  - Stays in DONE while `habOp`=1.
  - `habOp`=0 → IDLE, with `fimOp` cleared on that edge.
- `habOp` dropping during INIT or RUN aborts to IDLE. `result` keeps its previous value and `fimOp` stays 0.
- Accumulator width is 2*WIDTH; an unsigned product cannot overflow it.
- `regA` and `regB` keep their values after a multiply, so a repeated `habOp` recomputes the same product.

## Timing
- `fimA` and `fimB` rise on the edge that samples the WIDTH-th bit. Load latency is WIDTH cycles from the first sampled edge.
- `fimOp` and `result` update together, WIDTH+2 edges after the first edge with `habOp`=1 (1 INIT + WIDTH RUN + 1 DONE entry).
- All outputs are registered; no combinational path from input to output.
- Flags are level-held until the corresponding enable drops. They clear one edge after the drop.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Configuration
- `OP_DATAPATH_SIGNED_EN` defined:
  - Operands are two's complement.
  - INIT latches |A| and |B| plus a sign flag = A[MSB] XOR B[MSB].
  - DONE writes the negated accumulator when the sign flag is 1.
  - Latency is unchanged.
- `OP_DATAPATH_SIGNED_EN` undefined: unsigned multiply only; no sign logic is synthesised.

## Structure
- Package `op_datapath_pkg` holds:
  - the multiply state enum (IDLE, INIT, RUN, DONE);
  - the default WIDTH constant.
- Sub-module `serial_loader` holds the shift register, counter and done flag, with WIDTH as a parameter. It is instantiated twice, for A and B. The A-priority gating sits in the top level.

## Test plan
WIDTH=8 for all cases.
- Reset: hold `rst`=1 with random inputs → all outputs 0. Release `rst`, all enables 0 → outputs remain 0.
- Load A: `habA`=1, shift 0x0D MSB-first → `fimA`=1 after the 8th edge and `regA`=0x0D. Drop `habA` → `fimA`=0 one edge later.
- Abort load: `habA`=1 for 4 bits, drop it, then reload 0xA5 → `regA`=0xA5 and `fimA` rises after 8 bits, not 4.
- Unsigned multiply: A=0x0D, B=0x0B, `habOp`=1 → `fimOp`=1 and `result`=0x008F exactly 10 edges later. Without the macro, A=0xFD, B=0x05 → `result`=0x04F1.
- Signed multiply, with `OP_DATAPATH_SIGNED_EN`: A=0xFD, B=0x05 → `result`=0xFFF1. A=0xFD, B=0xFD → `result`=0x0009.
- Mid-op abort: drop `habOp` at RUN cycle 3 → `fimOp` stays 0 and `result` keeps its prior value. Assert `rst` during RUN → all outputs 0 with no clock edge needed.
